n64_poll_scheduler: RTL and testbench
=====================================

N64_POLL_SCHEDULER -- requirements
Module: n64_poll_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 24'd100000: maximum cycles to wait for poll_done after poll_start.
REQ-002 SHALL have parameter PERIOD_RST, default 24'd1000000: reset value of PERIOD register.
REQ-003 SHALL have port PCLK, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port PRESERN, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE, inputs, 1 each: APB3 slave control.
REQ-006 SHALL have port PADDR, input, 32: byte address; only [3:2] decoded.
REQ-007 SHALL have port PWDATA, input, 32: APB write data.
REQ-008 SHALL have ports PRDATA (output, 32), PREADY (output, 1), PSLVERR (output, 1): APB response.
REQ-009 SHALL have port poll_start, output, 1: one-cycle pulse launching one controller transaction.
REQ-010 SHALL have ports poll_done (input, 1), poll_err (input, 1), poll_data (input, 32): transceiver completion pulse, error flag and button word, sampled when poll_done=1.
REQ-011 SHALL have port irq, output, 1: level interrupt.

Function
REQ-012 SHALL drive PREADY=1 and PSLVERR=0 constantly; writes occur when PSEL&PENABLE&PWRITE; PRDATA is combinational from PADDR[3:2].
REQ-013 SHALL map 0x0 CTRL RW: bit0 EN, bit1 IRQ_EN, bit2 ONESHOT (write-1 requests one poll, reads 0).
REQ-014 SHALL map 0x4 PERIOD RW [23:0]: start-to-start interval in cycles; values below 16 SHALL be treated as 16; upper bits read 0.
REQ-015 SHALL map 0x8 STATUS: bit0 BUSY (state!=IDLE), bit1 VALID, bit2 IRQP (write-1-to-clear), bit3 TIMEOUT_SEEN (W1C), [15:8] ERRCNT (saturates at 255, any write to 0x8 with bit31=1 clears it).
REQ-016 SHALL map 0xC DATA RO: last good poll_data; an APB read of 0xC SHALL clear VALID; writes ignored.
REQ-017 SHALL implement FSM IDLE -> START -> WAIT -> IDLE.
REQ-018 IDLE: period counter decrements each cycle while EN=1; at counter==1 or pending trigger or ONESHOT write, go START.
REQ-019 START: poll_start=1 for exactly one cycle, period counter reloads, timeout counter loads TIMEOUT_CYC; next state WAIT.
REQ-020 WAIT: on poll_done, if poll_err=0 latch poll_data into DATA, set VALID; if poll_err=1 increment ERRCNT, DATA unchanged; set IRQP; go IDLE.
REQ-021 WAIT: timeout counter reaching 0 without poll_done SHALL increment ERRCNT, set TIMEOUT_SEEN and IRQP, go IDLE.
REQ-022 poll_done and timeout expiry in the same cycle: poll_done wins, no timeout recorded.
REQ-023 Period expiry during START/WAIT SHALL set a one-deep pending flag; further expiries while pending are dropped; pending causes START on the cycle after returning to IDLE.
REQ-024 poll_done while IDLE SHALL be ignored.
REQ-025 Clearing EN mid-WAIT: current transaction completes normally; pending flag cleared; no new periodic starts.
REQ-026 ONESHOT write while not IDLE SHALL set pending flag; works with EN=0.
REQ-027 irq = IRQ_EN & IRQP, registered-free combinational from flops.
REQ-028 IRQP set and APB W1C in same cycle: set wins.

Reset
REQ-029 With PRESERN=0 at a PCLK edge: state IDLE, CTRL=0, PERIOD=PERIOD_RST, DATA=0, STATUS=0, pending=0, counters loaded (period=PERIOD_RST), poll_start=0, irq=0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the transaction with no DATA update and no ERRCNT change.

Verification
REQ-031 PERIOD=100, CTRL=1, transceiver returns done+data 0x12345678 after 20 cycles -> poll_start every 100 cycles, DATA=0x12345678, VALID=1, read 0xC clears VALID.
REQ-032 poll_err=1 on done, IRQ_EN=1 -> ERRCNT=1, DATA unchanged, irq=1; write 0x4 to STATUS -> irq=0.
REQ-033 TIMEOUT_CYC=50, no poll_done -> return to IDLE 50 cycles after WAIT entry, TIMEOUT_SEEN=1, ERRCNT+1; done at cycle 50 exactly -> success, no timeout.
REQ-034 PERIOD=16, done after 40 cycles -> single pending start immediately after each completion, never two back-to-back extra starts.
REQ-035 256 errors -> ERRCNT=255; write 0x80000000 to 0x8 -> ERRCNT=0.
REQ-036 PRESERN=0 mid-WAIT then released -> all registers at reset values, first poll_start PERIOD_RST cycles after EN set.

Source files
------------

// File: rtl/n64_poll_scheduler.sv
// N64 controller poll scheduler: APB3 register block that launches periodic or one-shot
// transceiver polls, supervises them with a timeout and latches the returned button word.
module n64_poll_scheduler #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd100000,
    parameter logic [23:0] PERIOD_RST  = 24'd1000000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        poll_start,
    input  logic        poll_done,
    input  logic        poll_err,
    input  logic [31:0] poll_data,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_en;
    logic        r_irq_en;
    logic [23:0] r_period;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_irqp;
    logic        r_tseen;
    logic [7:0]  r_errcnt;
    logic        r_pending;
    logic [23:0] r_pcnt;
    logic [23:0] r_tcnt;
    logic        r_poll_start;

    logic        w_wr_ctrl;
    logic        w_wr_period;
    logic        w_wr_status;
    logic        w_rd_data;
    logic        w_oneshot;
    logic        w_expire;
    logic        w_busy;
    logic [23:0] w_period_eff;
    logic [7:0]  w_errcnt_base;
    logic [7:0]  w_errcnt_inc;
    logic        w_unused_ok;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign poll_start  = r_poll_start;
    assign irq         = r_irq_en & r_irqp;
    assign w_busy      = (r_state != S_IDLE);

    assign w_wr_ctrl   = PSEL & PENABLE & PWRITE & (PADDR[3:2] == 2'd0);
    assign w_wr_period = PSEL & PENABLE & PWRITE & (PADDR[3:2] == 2'd1);
    assign w_wr_status = PSEL & PENABLE & PWRITE & (PADDR[3:2] == 2'd2);
    assign w_rd_data   = PSEL & PENABLE & ~PWRITE & (PADDR[3:2] == 2'd3);
    assign w_oneshot   = w_wr_ctrl & PWDATA[2];

    assign w_period_eff = (r_period < 24'd16) ? 24'd16 : r_period;
    assign w_expire     = r_en & (r_pcnt == 24'd1);

    // ERRCNT clear and a same-cycle error event combine as clear-then-increment
    assign w_errcnt_base = (w_wr_status & PWDATA[31]) ? 8'd0 : r_errcnt;
    assign w_errcnt_inc  = (w_errcnt_base == 8'hFF) ? 8'hFF : w_errcnt_base + 8'd1;

    assign w_unused_ok = &{1'b0, PADDR[31:4], PADDR[1:0], PWDATA[30:24]};

    always_comb begin
        PRDATA = '0;
        case (PADDR[3:2])
            2'd0:    PRDATA = {29'd0, 1'b0, r_irq_en, r_en};
            2'd1:    PRDATA = {8'd0, r_period};
            2'd2:    PRDATA = {16'd0, r_errcnt, 4'd0, r_tseen, r_irqp, r_valid, w_busy};
            default: PRDATA = r_data;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_state      <= S_IDLE;
            r_en         <= 1'b0;
            r_irq_en     <= 1'b0;
            r_period     <= PERIOD_RST;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_irqp       <= 1'b0;
            r_tseen      <= 1'b0;
            r_errcnt     <= '0;
            r_pending    <= 1'b0;
            r_pcnt       <= PERIOD_RST;
            r_tcnt       <= TIMEOUT_CYC;
            r_poll_start <= 1'b0;
        end else begin
            r_poll_start <= 1'b0;
            if (w_wr_ctrl) begin
                r_en     <= PWDATA[0];
                r_irq_en <= PWDATA[1];
            end
            if (w_wr_period) r_period <= PWDATA[23:0];
            if (w_wr_status) begin
                if (PWDATA[2])  r_irqp   <= 1'b0;
                if (PWDATA[3])  r_tseen  <= 1'b0;
                if (PWDATA[31]) r_errcnt <= '0;
            end
            if (w_rd_data) r_valid <= 1'b0;

            // START reloads one short because the START cycle itself is the first of the interval
            if (r_state == S_START)     r_pcnt <= w_period_eff - 24'd1;
            else if (!r_en || w_expire) r_pcnt <= w_period_eff;
            else                        r_pcnt <= r_pcnt - 24'd1;

            if ((r_state != S_IDLE) && (w_expire || w_oneshot)) r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_expire || r_pending || w_oneshot) begin
                        r_state      <= S_START;
                        r_poll_start <= 1'b1;
                        r_pending    <= 1'b0;
                    end
                end
                S_START: begin
                    r_tcnt  <= TIMEOUT_CYC;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (poll_done) begin
                        if (poll_err) begin
                            r_errcnt <= w_errcnt_inc;
                        end else begin
                            r_data  <= poll_data;
                            r_valid <= 1'b1;
                        end
                        r_irqp  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_tcnt <= 24'd1) begin
                        r_errcnt <= w_errcnt_inc;
                        r_tseen  <= 1'b1;
                        r_irqp   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt - 24'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_wr_ctrl && !PWDATA[0] && !PWDATA[2]) r_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Directed bench for n64_poll_scheduler: a delayed-response transceiver model answers each
// poll_start, and start/irq edges are logged by cycle number for interval checks.
module tb_n64_poll_scheduler;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        poll_start;
    logic        poll_done = 1'b0;
    logic        poll_err = 1'b0;
    logic [31:0] poll_data = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_edge = 0;

    int          resp_delay = 20;
    bit          resp_en = 1'b0;
    logic        resp_err_v = 1'b0;
    logic [31:0] resp_data = '0;
    int          inj_cyc = -1;
    int          resp_cnt = 0;
    int          start_count = 0;
    int          st [0:1023];
    int          irq_count = 0;
    int          irq_rise = 0;
    logic        irq_q = 1'b0;

    n64_poll_scheduler #(
        .TIMEOUT_CYC(24'd50),
        .PERIOD_RST (24'd40)
    ) dut (
        .PCLK      (PCLK),
        .PRESERN   (PRESERN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .poll_start(poll_start),
        .poll_done (poll_done),
        .poll_err  (poll_err),
        .poll_data (poll_data),
        .irq       (irq)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Transceiver: poll_done arrives resp_delay cycles after the poll_start cycle
    always @(negedge PCLK) begin
        poll_done = 1'b0;
        poll_err  = 1'b0;
        if (cyc == inj_cyc) begin
            poll_done = 1'b1;
            poll_data = 32'h0BAD0BAD;
        end
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0 && resp_en) begin
                poll_done = 1'b1;
                poll_err  = resp_err_v;
                poll_data = resp_data;
            end
        end
        if (poll_start === 1'b1) begin
            if (start_count < 1024) st[start_count] = cyc;
            start_count = start_count + 1;
            resp_cnt = resp_delay;
        end
        if (irq === 1'b1 && irq_q !== 1'b1) begin
            irq_rise  = cyc;
            irq_count = irq_count + 1;
        end
        irq_q = irq;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        wr_edge = cyc;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (start_count < target && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        chk(tag, {31'd0, start_count >= target}, 32'd1);
    endtask

    task automatic wait_irq(input int target, input int budget, input string tag);
        int n = 0;
        while (irq_count < target && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        chk(tag, {31'd0, irq_count >= target}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int base;
        int s;
        int bi;

        repeat (3) @(posedge PCLK);
        #1 PRESERN = 1'b1;

        chk("rst_poll_start", {31'd0, poll_start}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("pready", {31'd0, PREADY}, 32'd1);
        chk("pslverr", {31'd0, PSLVERR}, 32'd0);
        apb_read(32'h0, rd);  chk("rst_ctrl", rd, 32'h0);
        apb_read(32'h4, rd);  chk("rst_period", rd, 32'd40);
        apb_read(32'h8, rd);  chk("rst_status", rd, 32'h0);
        apb_read(32'hC, rd);  chk("rst_data", rd, 32'h0);

        // Periodic polling at PERIOD=100, 20-cycle transceiver
        resp_en = 1'b1; resp_err_v = 1'b0; resp_delay = 20; resp_data = 32'h12345678;
        apb_write(32'h4, 32'd100);
        base = start_count;
        apb_write(32'h0, 32'h1);
        s = wr_edge;
        wait_starts(base + 1, 150, "a_first_wait");
        chk("a_first_start", 32'(st[base] - s), 32'd100);
        wait_starts(base + 2, 150, "a_second_wait");
        chk("a_interval", 32'(st[base + 1] - st[base]), 32'd100);
        repeat (25) @(negedge PCLK);
        apb_read(32'h8, rd);  chk("a_status", rd, 32'h6);
        apb_read(32'hC, rd);  chk("a_data", rd, 32'h12345678);
        apb_read(32'h8, rd);  chk("a_valid_clr", rd, 32'h4);
        apb_write(32'h0, 32'h0);
        base = start_count;
        inj_cyc = cyc + 4;
        repeat (150) @(negedge PCLK);
        chk("a_en_off_no_start", 32'(start_count), 32'(base));
        apb_read(32'hC, rd);  chk("idle_done_data", rd, 32'h12345678);
        apb_read(32'h8, rd);  chk("idle_done_status", rd, 32'h4);

        // Error completion with IRQ_EN, one-shot with EN=0
        apb_write(32'h8, 32'h4);
        resp_delay = 5; resp_err_v = 1'b1; resp_data = 32'hDEADBEEF;
        apb_write(32'h0, 32'h6);
        repeat (12) @(negedge PCLK);
        chk("b_irq", {31'd0, irq}, 32'd1);
        apb_read(32'h8, rd);  chk("b_status", rd, 32'h104);
        apb_read(32'hC, rd);  chk("b_data_kept", rd, 32'h12345678);
        apb_read(32'h0, rd);  chk("b_ctrl_oneshot_rd0", rd, 32'h2);
        apb_write(32'h8, 32'h4);
        chk("b_irq_clr", {31'd0, irq}, 32'd0);

        // Timeout: 1 START cycle + 50 WAIT cycles before irq rises
        resp_en = 1'b0;
        base = start_count; bi = irq_count;
        apb_write(32'h0, 32'h6);
        s = wr_edge;
        wait_starts(base + 1, 10, "c_start_wait");
        chk("c_start_cyc", 32'(st[base]), 32'(s));
        wait_irq(bi + 1, 100, "c_irq_wait");
        chk("c_timeout_len", 32'(irq_rise - st[base]), 32'd51);
        apb_read(32'h8, rd);  chk("c_status", rd, 32'h20C);
        apb_write(32'h8, 32'hC);
        apb_read(32'h8, rd);  chk("c_status_clr", rd, 32'h200);

        // Done on the last WAIT cycle wins over timeout
        resp_en = 1'b1; resp_err_v = 1'b0; resp_delay = 50; resp_data = 32'hA5A50001;
        base = start_count; bi = irq_count;
        apb_write(32'h0, 32'h6);
        wait_starts(base + 1, 10, "d_start_wait");
        wait_irq(bi + 1, 100, "d_irq_wait");
        chk("d_done_len", 32'(irq_rise - st[base]), 32'd51);
        apb_read(32'h8, rd);  chk("d_status", rd, 32'h206);
        apb_read(32'hC, rd);  chk("d_data", rd, 32'hA5A50001);
        apb_write(32'h8, 32'h4);

        // PERIOD=16 with 40-cycle transceiver: single pending start per completion
        apb_write(32'h4, 32'hFF000010);
        apb_read(32'h4, rd);  chk("e_period_rd", rd, 32'h10);
        resp_delay = 40;
        base = start_count;
        apb_write(32'h0, 32'h1);
        s = wr_edge;
        wait_starts(base + 4, 400, "e_wait");
        chk("e_first", 32'(st[base] - s), 32'd16);
        chk("e_int1", 32'(st[base + 1] - st[base]), 32'd42);
        chk("e_int2", 32'(st[base + 2] - st[base + 1]), 32'd42);
        chk("e_int3", 32'(st[base + 3] - st[base + 2]), 32'd42);
        repeat (20) @(negedge PCLK);
        apb_write(32'h0, 32'h0);
        base = start_count;
        repeat (120) @(negedge PCLK);
        chk("e_en_off_mid_wait", 32'(start_count), 32'(base));

        // PERIOD below 16 behaves as 16
        apb_write(32'h4, 32'd3);
        resp_delay = 5;
        base = start_count;
        apb_write(32'h0, 32'h1);
        s = wr_edge;
        wait_starts(base + 3, 200, "f_wait");
        chk("f_first", 32'(st[base] - s), 32'd16);
        chk("f_int1", 32'(st[base + 1] - st[base]), 32'd16);
        chk("f_int2", 32'(st[base + 2] - st[base + 1]), 32'd16);
        apb_write(32'h0, 32'h0);
        repeat (30) @(negedge PCLK);

        // ERRCNT saturation (two errors already recorded)
        resp_delay = 1; resp_err_v = 1'b1;
        for (int i = 0; i < 253; i++) begin
            apb_write(32'h0, 32'h4);
            repeat (3) @(posedge PCLK);
        end
        apb_read(32'h8, rd);  chk("g_errcnt_255", {24'd0, rd[15:8]}, 32'd255);
        for (int i = 0; i < 3; i++) begin
            apb_write(32'h0, 32'h4);
            repeat (3) @(posedge PCLK);
        end
        apb_read(32'h8, rd);  chk("g_errcnt_sat", {24'd0, rd[15:8]}, 32'd255);
        apb_write(32'h8, 32'h80000000);
        apb_read(32'h8, rd);  chk("g_errcnt_clr", {24'd0, rd[15:8]}, 32'd0);

        // Reset in the middle of WAIT
        resp_en = 1'b0;
        apb_write(32'h0, 32'h4);
        repeat (10) @(posedge PCLK);
        #1 PRESERN = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESERN = 1'b1;
        chk("h_irq", {31'd0, irq}, 32'd0);
        apb_read(32'h0, rd);  chk("h_ctrl", rd, 32'h0);
        apb_read(32'h4, rd);  chk("h_period", rd, 32'd40);
        apb_read(32'h8, rd);  chk("h_status", rd, 32'h0);
        apb_read(32'hC, rd);  chk("h_data", rd, 32'h0);
        repeat (60) @(negedge PCLK);
        apb_read(32'h8, rd);  chk("h_status_later", rd, 32'h0);
        resp_en = 1'b1; resp_err_v = 1'b0; resp_delay = 5;
        base = start_count;
        apb_write(32'h0, 32'h1);
        s = wr_edge;
        wait_starts(base + 1, 100, "h_start_wait");
        chk("h_first_start", 32'(st[base] - s), 32'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
